// File: rtl/pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// pipe_stage_regs
//
// The three in-order pipeline boundary registers of the 16-bit CPU, kept
// together in one bank: IF/ID, ID/EX and EX/MEM. Each group captures its
// upstream combinational values on the rising edge of clk and presents them
// to the following stage for the next cycle.
//
// The groups are deliberately independent. ID/EX is fed by the external
// decoder and EX/MEM by the external ALU, so nothing chains internally from
// one group to the next. A synchronous reset turns every group into a bubble
// (all zeros): an all-zero instruction is a NOP, and wreg=0 means no write.
//
// Ports:
//   clk, rst                        clock (rising edge) and synchronous
//                                   active-high reset
//   if_pc, if_inst                  fetch-stage PC and instruction word
//   id_pc, id_inst                  registered PC / instruction to decode
//   id_aluop, id_alusel, id_reg1,
//   id_reg2, id_wd, id_wreg         decoder outputs feeding ID/EX
//   ex_aluop, ex_alusel, ex_reg1,
//   ex_reg2, ex_wd, ex_wreg         registered decode results to execute
//   ex_res_wd, ex_res_wreg,
//   ex_res_wdata                    execute-stage results feeding EX/MEM
//   mem_wd, mem_wreg, mem_wdata     registered execute results to MEM
// ---------------------------------------------------------------------------
module pipe_stage_regs #(
   parameter int DATA_W   = 16,
   parameter int INST_W   = 16,
   parameter int PC_W     = 16,
   parameter int RADDR_W  = 4,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3
) (
   input  logic                clk,
   input  logic                rst,

   // IF/ID
   input  logic [PC_W-1:0]     if_pc,
   input  logic [INST_W-1:0]   if_inst,
   output logic [PC_W-1:0]     id_pc,
   output logic [INST_W-1:0]   id_inst,

   // ID/EX
   input  logic [ALUOP_W-1:0]  id_aluop,
   input  logic [ALUSEL_W-1:0] id_alusel,
   input  logic [DATA_W-1:0]   id_reg1,
   input  logic [DATA_W-1:0]   id_reg2,
   input  logic [RADDR_W-1:0]  id_wd,
   input  logic                id_wreg,
   output logic [ALUOP_W-1:0]  ex_aluop,
   output logic [ALUSEL_W-1:0] ex_alusel,
   output logic [DATA_W-1:0]   ex_reg1,
   output logic [DATA_W-1:0]   ex_reg2,
   output logic [RADDR_W-1:0]  ex_wd,
   output logic                ex_wreg,

   // EX/MEM
   input  logic [RADDR_W-1:0]  ex_res_wd,
   input  logic                ex_res_wreg,
   input  logic [DATA_W-1:0]   ex_res_wdata,
   output logic [RADDR_W-1:0]  mem_wd,
   output logic                mem_wreg,
   output logic [DATA_W-1:0]   mem_wdata
);

   logic [PC_W-1:0]     r_idPc;
   logic [INST_W-1:0]   r_idInst;

   logic [ALUOP_W-1:0]  r_exAluop;
   logic [ALUSEL_W-1:0] r_exAlusel;
   logic [DATA_W-1:0]   r_exReg1;
   logic [DATA_W-1:0]   r_exReg2;
   logic [RADDR_W-1:0]  r_exWd;
   logic                r_exWreg;

   logic [RADDR_W-1:0]  r_memWd;
   logic                r_memWreg;
   logic [DATA_W-1:0]   r_memWdata;

   // IF/ID boundary: capture the fetched PC and instruction word. Reset
   // loads a zero instruction, which decode treats as a NOP.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idPc   <= '0;
         r_idInst <= '0;
      end else begin
         r_idPc   <= if_pc;
         r_idInst <= if_inst;
      end
   end

   // ID/EX boundary: capture the decoded operation, operands and destination.
   // The destination address is latched even when wreg is low; only wreg
   // decides whether a write happens later, so no gating is needed here.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exAluop  <= '0;
         r_exAlusel <= '0;
         r_exReg1   <= '0;
         r_exReg2   <= '0;
         r_exWd     <= '0;
         r_exWreg   <= 1'b0;
      end else begin
         r_exAluop  <= id_aluop;
         r_exAlusel <= id_alusel;
         r_exReg1   <= id_reg1;
         r_exReg2   <= id_reg2;
         r_exWd     <= id_wd;
         r_exWreg   <= id_wreg;
      end
   end

   // EX/MEM boundary: capture the ALU result and its write-back target.
   // Like ID/EX, address and data travel regardless of the write enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_memWd    <= '0;
         r_memWreg  <= 1'b0;
         r_memWdata <= '0;
      end else begin
         r_memWd    <= ex_res_wd;
         r_memWreg  <= ex_res_wreg;
         r_memWdata <= ex_res_wdata;
      end
   end

   // Outputs come straight from the registers, so no input reaches an output
   // without passing through a clock edge.
   assign id_pc     = r_idPc;
   assign id_inst   = r_idInst;

   assign ex_aluop  = r_exAluop;
   assign ex_alusel = r_exAlusel;
   assign ex_reg1   = r_exReg1;
   assign ex_reg2   = r_exReg2;
   assign ex_wd     = r_exWd;
   assign ex_wreg   = r_exWreg;

   assign mem_wd    = r_memWd;
   assign mem_wreg  = r_memWreg;
   assign mem_wdata = r_memWdata;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_regs
//
// Self-checking bench for pipe_stage_regs. A reference model holds a queue of
// "what the inputs were at each rising edge, or a bubble if reset was high";
// every cycle after the first reset edge the front of that queue is what all
// three stages must show. A directed sequence pins the model with
// hand-computed literals, and a randomized run with occasional mid-stream
// resets follows.
// ---------------------------------------------------------------------------
module tb_pipe_stage_regs;

   logic        clk;
   logic        rst;
   logic [15:0] if_pc;
   logic [15:0] if_inst;
   logic [15:0] id_pc;
   logic [15:0] id_inst;
   logic [7:0]  id_aluop;
   logic [2:0]  id_alusel;
   logic [15:0] id_reg1;
   logic [15:0] id_reg2;
   logic [3:0]  id_wd;
   logic        id_wreg;
   logic [7:0]  ex_aluop;
   logic [2:0]  ex_alusel;
   logic [15:0] ex_reg1;
   logic [15:0] ex_reg2;
   logic [3:0]  ex_wd;
   logic        ex_wreg;
   logic [3:0]  ex_res_wd;
   logic        ex_res_wreg;
   logic [15:0] ex_res_wdata;
   logic [3:0]  mem_wd;
   logic        mem_wreg;
   logic [15:0] mem_wdata;

   int totalChecks = 0;
   int badChecks   = 0;

   pipe_stage_regs dut (
      .clk          (clk),
      .rst          (rst),
      .if_pc        (if_pc),
      .if_inst      (if_inst),
      .id_pc        (id_pc),
      .id_inst      (id_inst),
      .id_aluop     (id_aluop),
      .id_alusel    (id_alusel),
      .id_reg1      (id_reg1),
      .id_reg2      (id_reg2),
      .id_wd        (id_wd),
      .id_wreg      (id_wreg),
      .ex_aluop     (ex_aluop),
      .ex_alusel    (ex_alusel),
      .ex_reg1      (ex_reg1),
      .ex_reg2      (ex_reg2),
      .ex_wd        (ex_wd),
      .ex_wreg      (ex_wreg),
      .ex_res_wd    (ex_res_wd),
      .ex_res_wreg  (ex_res_wreg),
      .ex_res_wdata (ex_res_wdata),
      .mem_wd       (mem_wd),
      .mem_wreg     (mem_wreg),
      .mem_wdata    (mem_wdata)
   );

   // 10-time-unit clock, first rising edge at t=5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: count it, and report it if the values differ.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                  name, actual, expected, $time);
      end
   endtask

   // Wait for the next rising edge and settle past the model's compare point.
   task automatic stepEdge();
      @(posedge clk);
      #2;
   endtask

   // Randomize every data input, and occasionally assert reset.
   task automatic applyStimulus();
      @(negedge clk);
      if_pc        = 16'($urandom);
      if_inst      = 16'($urandom);
      id_aluop     = 8'($urandom);
      id_alusel    = 3'($urandom);
      id_reg1      = 16'($urandom);
      id_reg2      = 16'($urandom);
      id_wd        = 4'($urandom);
      id_wreg      = 1'($urandom);
      ex_res_wd    = 4'($urandom);
      ex_res_wreg  = 1'($urandom);
      ex_res_wdata = 16'($urandom);
      rst          = ($urandom_range(0, 19) == 0);
   endtask

   // Reference model: each rising edge records the full input bundle (or a
   // bubble if reset is high); the output after that edge must equal it.
   // Bundle layout: [100:69] IF/ID, [68:21] ID/EX, [20:0] EX/MEM.
   logic [100:0] expQ[$];
   logic [100:0] sampledVec;
   logic [100:0] expVec;
   logic         seenReset = 1'b0;

   always @(posedge clk) begin
      sampledVec = rst ? 101'd0 :
                   {if_pc, if_inst,
                    id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
                    ex_res_wd, ex_res_wreg, ex_res_wdata};
      if (rst) seenReset = 1'b1;
      if (seenReset) begin
         expQ.push_back(sampledVec);
         #1;
         expVec = expQ.pop_front();
         checkOutput("model_if_id", 64'({id_pc, id_inst}), 64'(expVec[100:69]));
         checkOutput("model_id_ex",
                     64'({ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg}),
                     64'(expVec[68:21]));
         checkOutput("model_ex_mem", 64'({mem_wd, mem_wreg, mem_wdata}),
                     64'(expVec[20:0]));
      end
   end

   // Directed sequence with literal expectations, then randomized traffic.
   initial begin
      logic [15:0] instSeq[3];
      instSeq[0] = 16'h1111;
      instSeq[1] = 16'h2222;
      instSeq[2] = 16'h3333;

      rst          = 1'b1;
      if_pc        = 16'h0004;
      if_inst      = 16'h3443;
      id_aluop     = 8'h25;
      id_alusel    = 3'd1;
      id_reg1      = 16'h0003;
      id_reg2      = 16'h0006;
      id_wd        = 4'h5;
      id_wreg      = 1'b1;
      ex_res_wd    = 4'h0;
      ex_res_wreg  = 1'b0;
      ex_res_wdata = 16'h0000;

      // Four reset edges with live inputs: everything stays a bubble.
      repeat (4) begin
         stepEdge();
         checkOutput("reset_id_pc", 64'(id_pc), 64'h0);
         checkOutput("reset_id_inst", 64'(id_inst), 64'h0);
         checkOutput("reset_ex_reg1", 64'(ex_reg1), 64'h0);
         checkOutput("reset_ex_wreg", 64'(ex_wreg), 64'h0);
         checkOutput("reset_mem_wdata", 64'(mem_wdata), 64'h0);
      end

      // Release reset: the first edge loads the held inputs.
      @(negedge clk);
      rst = 1'b0;
      stepEdge();
      checkOutput("load_id_inst", 64'(id_inst), 64'h3443);
      checkOutput("load_id_pc", 64'(id_pc), 64'h0004);
      checkOutput("load_ex_reg1", 64'(ex_reg1), 64'h0003);
      checkOutput("load_ex_reg2", 64'(ex_reg2), 64'h0006);
      checkOutput("load_ex_wreg", 64'(ex_wreg), 64'h1);
      checkOutput("load_ex_wd", 64'(ex_wd), 64'h5);
      checkOutput("load_ex_aluop", 64'(ex_aluop), 64'h25);

      // EX/MEM: new result does not appear before the edge, then does.
      @(negedge clk);
      ex_res_wd    = 4'h1;
      ex_res_wreg  = 1'b1;
      ex_res_wdata = 16'h0009;
      #1;
      checkOutput("mem_hold_wdata", 64'(mem_wdata), 64'h0);
      checkOutput("mem_hold_wreg", 64'(mem_wreg), 64'h0);
      stepEdge();
      checkOutput("mem_wd", 64'(mem_wd), 64'h1);
      checkOutput("mem_wreg", 64'(mem_wreg), 64'h1);
      checkOutput("mem_wdata", 64'(mem_wdata), 64'h0009);

      // Instruction stream: id_inst trails if_inst by exactly one edge.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if_inst = instSeq[i];
         #1;
         checkOutput("stream_before_edge", 64'(id_inst),
                     (i == 0) ? 64'h3443 : 64'(instSeq[i-1]));
         stepEdge();
         checkOutput("stream_after_edge", 64'(id_inst), 64'(instSeq[i]));
      end

      // One mid-stream reset edge with non-zero inputs, then reload.
      @(negedge clk);
      rst = 1'b1;
      stepEdge();
      checkOutput("midrst_id_inst", 64'(id_inst), 64'h0);
      checkOutput("midrst_ex_reg2", 64'(ex_reg2), 64'h0);
      checkOutput("midrst_mem_wreg", 64'(mem_wreg), 64'h0);
      checkOutput("midrst_mem_wdata", 64'(mem_wdata), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      stepEdge();
      checkOutput("reload_id_inst", 64'(id_inst), 64'h3333);
      checkOutput("reload_ex_reg2", 64'(ex_reg2), 64'h0006);
      checkOutput("reload_mem_wdata", 64'(mem_wdata), 64'h0009);

      // Destination fields travel even with the write enable low.
      @(negedge clk);
      id_wreg = 1'b0;
      id_wd   = 4'hF;
      id_reg1 = 16'hFFFF;
      stepEdge();
      checkOutput("ungated_ex_wreg", 64'(ex_wreg), 64'h0);
      checkOutput("ungated_ex_wd", 64'(ex_wd), 64'hF);
      checkOutput("ungated_ex_reg1", 64'(ex_reg1), 64'hFFFF);

      // Randomized traffic; the model process checks every cycle.
      repeat (300) applyStimulus();
      @(negedge clk);
      rst = 1'b0;
      stepEdge();

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview: Bank of the three in-order pipeline boundary registers of the 16-bit CPU: IF/ID, ID/EX and EX/MEM. Each stage latches its upstream combinational outputs on the rising clock edge and presents them to the next stage one cycle later. A synchronous reset loads a bubble (all zeros, no register write).

Parameters:
DATA_W, 16, register/operand/result width
INST_W, 16, instruction width
PC_W, 16, instruction address width
RADDR_W, 4, register-file address width
ALUOP_W, 8, ALU operation code width
ALUSEL_W, 3, ALU result-select width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
if_pc  in  PC_W  fetch-stage PC
if_inst  in  INST_W  fetched instruction word
id_pc  out  PC_W  registered PC to decode
id_inst  out  INST_W  registered instruction to decode
id_aluop  in  ALUOP_W  decoded ALU op
id_alusel  in  ALUSEL_W  decoded result select
id_reg1  in  DATA_W  operand 1 from decode
id_reg2  in  DATA_W  operand 2 from decode
id_wd  in  RADDR_W  destination register address
id_wreg  in  1  destination write enable
ex_aluop  out  ALUOP_W  registered ALU op
ex_alusel  out  ALUSEL_W  registered result select
ex_reg1  out  DATA_W  registered operand 1
ex_reg2  out  DATA_W  registered operand 2
ex_wd  out  RADDR_W  registered destination address
ex_wreg  out  1  registered write enable
ex_res_wd  in  RADDR_W  execute-stage destination address
ex_res_wreg  in  1  execute-stage write enable
ex_res_wdata  in  DATA_W  execute-stage ALU result
mem_wd  out  RADDR_W  registered destination address to MEM
mem_wreg  out  1  registered write enable to MEM
mem_wdata  out  DATA_W  registered result to MEM

Behaviour:
- Three independent register groups share clk and rst. Each group has exactly 1 cycle latency, with no combinational input-to-output path.
- Rising edge with rst=1: every output is set to 0 (id_pc, id_inst, ex_*, mem_*). All-zero instruction is a NOP and wreg=0 means no write. Reset dominates the data inputs on the same edge.
- Rising edge with rst=0: each output takes its corresponding input value sampled at that edge. Values are stored bit-exact, with no width change, sign change or arithmetic.
- Between edges, outputs hold their value. Before the first edge they are undefined; the bench must apply rst for at least 1 edge.
- Reset asserted mid-stream: on the next edge all three stages become bubbles simultaneously. Instructions in flight are discarded, not completed.
- Reset deasserted: the first edge with rst=0 loads live inputs into all stages at once. Downstream stages therefore carry whatever upstream combinational logic presents, and upstream logic must itself drive bubbles during reset.
- Stages do not chain internally. ID/EX inputs come from the external decoder and EX/MEM inputs from the external ALU. A value at if_inst reaches ex_* only through external decode: 2 edges end-to-end.
- No stall, flush, enable or handshake inputs; every edge advances every stage.
- wd/wdata fields are latched even when wreg=0 (no gating).

Test Plan:
- Hold rst=1 for 4 edges with inputs if_pc=0x0004, if_inst=0x3443, id_reg1=0x0003, id_reg2=0x0006, id_wreg=1 -> all outputs 0 after the first edge and they remain 0.
- Release rst, keep inputs constant -> after 1 edge: id_inst=0x3443, id_pc=0x0004, ex_reg1=0x0003, ex_reg2=0x0006, ex_wreg=1, ex_wd=id_wd.
- Drive ex_res_wd=1, ex_res_wreg=1, ex_res_wdata=0x0009 -> next edge: mem_wd=1, mem_wreg=1, mem_wdata=0x0009; unchanged before the edge.
- Change if_inst every cycle (0x1111, 0x2222, 0x3333) -> id_inst follows exactly 1 cycle behind with no skipped or duplicated values.
- Assert rst for one edge mid-sequence with non-zero inputs -> all outputs 0 after that edge; next edge with rst=0 reloads current inputs.
- id_wreg=0 with id_wd=0xF, id_reg1=0xFFFF -> ex_wreg=0, ex_wd=0xF, ex_reg1=0xFFFF (fields latched ungated).
